and16: RTL and testbench

- 16-bit bitwise AND datapath element in the elementary-logic-gate library, used by ALU and datapath blocks.
- Provides a purely combinational result `y = a & b` that settles within the same time step as its inputs.
- Also provides a one-cycle registered copy of the result, with a valid flag and a zero flag, for pipelined consumers.

---
 rtl/logic_pkg.sv | 15 +
 rtl/and_bit.sv | 17 +
 rtl/and16.sv | 61 ++++++
 tb/tb_and16.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// +----------------------------------------------------------------------+
// | logic_pkg: word width and word type shared by the 16-bit gate cells. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package logic_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : logic_pkg

`default_nettype wire

// File: rtl/and_bit.sv
// +----------------------------------------------------------------------+
// | and_bit: single-bit AND cell, replicated to build wide AND gates.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module and_bit (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule : and_bit

`default_nettype wire

// File: rtl/and16.sv
// +----------------------------------------------------------------------+
// | and16: 16-bit bitwise AND with a combinational result and a one-     |
// | cycle registered copy carrying valid and zero flags.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module and16
  import logic_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             zero_q
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_out_valid;
  logic             r_zero_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      and_bit u_and_bit (
        .a (a[i]),
        .b (b[i]),
        .y (w_y[i])
      );
    end
  endgenerate

  // Idle cycles keep the last result and its zero flag; only valid drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_y_q       <= '0;
      r_out_valid <= 1'b0;
      r_zero_q    <= 1'b0;
    end else if (in_valid) begin
      r_y_q       <= w_y;
      r_out_valid <= 1'b1;
      r_zero_q    <= (w_y == '0);
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y         = w_y;
  assign y_q       = r_y_q;
  assign out_valid = r_out_valid;
  assign zero_q    = r_zero_q;

endmodule : and16

`default_nettype wire

// File: tb/tb_and16.sv
// +----------------------------------------------------------------------+
// | tb_and16: directed and random vectors for and16 against a reference  |
// | model of the combinational and registered outputs.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_and16;
  import logic_pkg::*;

  logic  clk;
  logic  reset_n;
  word_t a;
  word_t b;
  logic  in_valid;
  word_t y;
  word_t y_q;
  logic  out_valid;
  logic  zero_q;

  int n_vec;
  int n_err;

  // Reference model of the registered outputs.
  word_t m_y_q;
  logic  m_valid;
  logic  m_zero;
  logic  m_known;

  and16 #(.WIDTH(WORD_WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .y         (y),
    .y_q       (y_q),
    .out_valid (out_valid),
    .zero_q    (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_y_q   = '0;
      m_valid = 1'b0;
      m_zero  = 1'b0;
      m_known = 1'b1;
    end else if (in_valid) begin
      m_y_q   = a & b;
      m_valid = 1'b1;
      m_zero  = ((a & b) == 16'h0000);
    end else begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_y", {16'h0, y}, {16'h0, a & b});
    if (m_known) begin
      check("model_y_q", {16'h0, y_q}, {16'h0, m_y_q});
      check("model_out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      check("model_zero_q", {31'h0, zero_q}, {31'h0, m_zero});
    end
  end

  task automatic set_in(input word_t na, input word_t nb, input logic v, input logic rn);
    a        = na;
    b        = nb;
    in_valid = v;
    reset_n  = rn;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string name, input word_t ey, input logic ev, input logic ez);
    check({name, "_y_q"}, {16'h0, y_q}, {16'h0, ey});
    check({name, "_out_valid"}, {31'h0, out_valid}, {31'h0, ev});
    check({name, "_zero_q"}, {31'h0, zero_q}, {31'h0, ez});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_known = 1'b0;
    m_y_q   = '0;
    m_valid = 1'b0;
    m_zero  = 1'b0;

    // Combinational vectors, checked within the same time step region.
    set_in(16'h5555, 16'h5555, 1'b0, 1'b0); #1 check("comb_equal", {16'h0, y}, 32'h5555);
    set_in(16'hCCCC, 16'h5555, 1'b0, 1'b0); #1 check("comb_mix", {16'h0, y}, 32'h4444);
    set_in(16'h85DD, 16'hFFFF, 1'b0, 1'b0); #1 check("comb_ones", {16'h0, y}, 32'h85DD);
    set_in(16'h0515, 16'h0000, 1'b0, 1'b0); #1 check("comb_zero", {16'h0, y}, 32'h0000);

    // Reset held two edges with valid input present.
    set_in(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    #0 check("rst_comb_y", {16'h0, y}, 32'hFFFF);
    for (int i = 0; i < 2; i++) begin
      edge_step();
      check("rst_comb_y_after", {16'h0, y}, 32'hFFFF);
      check_reg("rst", 16'h0000, 1'b0, 1'b0);
    end

    // Back-to-back stream.
    set_in(16'h5555, 16'h5555, 1'b1, 1'b1); edge_step();
    check_reg("stream1", 16'h5555, 1'b1, 1'b0);
    set_in(16'hCCCC, 16'h5555, 1'b1, 1'b1); edge_step();
    check_reg("stream2", 16'h4444, 1'b1, 1'b0);
    set_in(16'h0515, 16'h0000, 1'b1, 1'b1); edge_step();
    check_reg("stream3", 16'h0000, 1'b1, 1'b1);

    // Hold after capturing 4444.
    set_in(16'hCCCC, 16'h5555, 1'b1, 1'b1); edge_step();
    check_reg("cap4444", 16'h4444, 1'b1, 1'b0);
    set_in(16'hFFFF, 16'h5555, 1'b0, 1'b1); edge_step();
    check_reg("hold", 16'h4444, 1'b0, 1'b0);

    // Reset dominates valid in the same cycle.
    set_in(16'hAAAA, 16'hAAAA, 1'b1, 1'b0); edge_step();
    check_reg("rst_mid", 16'h0000, 1'b0, 1'b0);
    set_in(16'hAAAA, 16'hAAAA, 1'b1, 1'b1); edge_step();
    check_reg("after_rst", 16'hAAAA, 1'b1, 1'b0);

    // A reset pulse between edges must not disturb the registers.
    set_in(16'h1234, 16'h00FF, 1'b0, 1'b0); #2;
    check_reg("rst_glitch", 16'hAAAA, 1'b1, 1'b0);
    reset_n = 1'b1;
    edge_step();
    check_reg("rst_glitch_next", 16'hAAAA, 1'b0, 1'b0);

    // Random operands; registered outputs are tracked by the model.
    for (int i = 0; i < 1000; i++) begin
      word_t ra;
      word_t rb;
      ra = word_t'($urandom);
      rb = word_t'($urandom);
      if (i % 7 == 0) rb = 16'hFFFF;
      if (i % 11 == 0) rb = 16'h0000;
      if (i % 13 == 0) rb = ra;
      set_in(ra, rb, ($urandom_range(0, 3) != 0), 1'b1);
      #1 check("rand_y", {16'h0, y}, {16'h0, ra & rb});
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_and16

`default_nettype wire
